// File: rtl/comms_ctrl_mp.sv
// comms_ctrl_mp
//   Multi-port comms controller. Arbitrates round-robin between NUM_PORTS RX
//   UART ports, decodes config-write / config-read / data packets, drives the
//   regmap and the event FIFO write port, and keeps saturating packet,
//   bad-packet and FIFO high-water counters.
//
//   Optional feature macro: COMMS_CTRL_MP_MAILBOX_EN
//     defined   -> counter changes are mirrored into the regmap byte-serially
//                  (LSB first) at TP_ADDR / BP_ADDR / HW_ADDR via a MAILBOX state.
//     undefined -> no MAILBOX state; write_regmap is driven only by config writes.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   rx_data, rx_data_flag   packed RX words (port p = slice p) and per-port valid
//   rx_ack                  one-hot pulse consuming the granted port's word
//   pre_event, load_event   event word from the router and its pending flag
//   chip_id                 this chip's ID
//   regmap_*                regmap read/write access
//   fifo_counter            FIFO occupancy, feeds the high-water counter
//   output_event            word presented to FIFO / TX
//   write_fifo_n, fifo_ack  FIFO write strobe (active low) and ack
//   send_config_data        request to send output_event directly
//   total_packets, bad_packets, fifo_high_water   saturating counters
//   comms_busy              high whenever the FSM is not in READY
module comms_ctrl_mp #(
    parameter int          WIDTH        = 64,
    parameter int          NUM_PORTS    = 4,
    parameter logic [7:0]  GLOBAL_ID    = 8'd255,
    parameter logic [31:0] MAGIC        = 32'h8950_4E47,
    parameter int          READ_LATENCY = 5,
    parameter int          TIMEOUT      = 15,
    parameter int          CNT_BYTES    = 2,
    parameter logic [7:0]  TP_ADDR      = 8'd240,
    parameter logic [7:0]  BP_ADDR      = 8'd244,
    parameter logic [7:0]  HW_ADDR      = 8'd248
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS*(WIDTH-1)-1:0] rx_data,
    input  logic [NUM_PORTS-1:0]           rx_data_flag,
    output logic [NUM_PORTS-1:0]           rx_ack,
    input  logic [WIDTH-2:0]               pre_event,
    input  logic                           load_event,
    input  logic [7:0]                     chip_id,
    input  logic [7:0]                     regmap_read_data,
    input  logic [11:0]                    fifo_counter,
    output logic [WIDTH-2:0]               output_event,
    output logic                           write_fifo_n,
    output logic                           fifo_ack,
    output logic                           send_config_data,
    output logic                           write_regmap,
    output logic                           read_regmap,
    output logic [7:0]                     regmap_address,
    output logic [7:0]                     regmap_write_data,
    output logic [8*CNT_BYTES-1:0]         total_packets,
    output logic [8*CNT_BYTES-1:0]         bad_packets,
    output logic [8*CNT_BYTES-1:0]         fifo_high_water,
    output logic                           comms_busy
);
    localparam int W  = WIDTH - 1;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = 8 * CNT_BYTES;
    // WAIT dwells a single cycle, which is always within the TIMEOUT bound.
    localparam int WAIT_CYC = (TIMEOUT > 1) ? 1 : ((TIMEOUT < 1) ? 1 : TIMEOUT);

    typedef enum logic [3:0] {
        S_READY, S_DECODE, S_CFG_WRITE, S_CFG_READ, S_PASS, S_PASS_CFG,
        S_LOAD_EVENT, S_WRITE_FIFO, S_BAD, S_WAIT
`ifdef COMMS_CTRL_MP_MAILBOX_EN
        , S_MAILBOX
`endif
    } state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d, grant;
    logic            found;
    logic [W-1:0]    word, word_d;
    logic [3:0]      cnt, cnt_d;

    // Next values of the registered outputs.
    logic [NUM_PORTS-1:0] rx_ack_d;
    logic [W-1:0]         output_event_d;
    logic                 write_fifo_n_d, fifo_ack_d, send_cfg_d;
    logic                 write_regmap_d, read_regmap_d;
    logic [7:0]           addr_d, wdata_d;
    logic                 inc_tp, inc_bp;
    logic                 tp_set, bp_set, hw_set;
    logic [CW-1:0]        fc_w;

    // Packet fields of the latched word.
    logic [1:0] pkt_op;
    logic [7:0] pkt_id, pkt_addr, pkt_data;
    logic       magic_ok, id_match, is_bcast;

    assign pkt_op   = word[1:0];
    assign pkt_id   = word[9:2];
    assign pkt_addr = word[17:10];
    assign pkt_data = word[25:18];
    assign magic_ok = (word[57:26] == MAGIC);
    assign is_bcast = (pkt_id == GLOBAL_ID);
    assign id_match = (pkt_id == chip_id) || is_bcast;

    // FIFO occupancy zero-extended or truncated to the counter width.
    generate
        if (CW >= 12) begin : g_fc_ext
            assign fc_w = {{(CW-12){1'b0}}, fifo_counter};
        end else begin : g_fc_trunc
            assign fc_w = fifo_counter[CW-1:0];
        end
    endgenerate

    assign tp_set = inc_tp && (total_packets != {CW{1'b1}});
    assign bp_set = inc_bp && (bad_packets   != {CW{1'b1}});
    assign hw_set = (fc_w > fifo_high_water);

`ifdef COMMS_CTRL_MP_MAILBOX_EN
    logic [2:0]    chg, pend, pend_d, redo, mb_clr;
    logic [1:0]    mb_byte, mb_byte_d, mb_sel;
    logic [7:0]    mb_base;
    logic [CW-1:0] mb_cnt;
`endif

    // First flagged port at or after the round-robin pointer.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && rx_data_flag[(int'(ptr) + i) % NUM_PORTS]) begin
                found = 1'b1;
                grant = PW'((int'(ptr) + i) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d        = state;
        ptr_d          = ptr;
        word_d         = word;
        cnt_d          = cnt;
        rx_ack_d       = '0;
        output_event_d = output_event;
        write_fifo_n_d = 1'b1;
        fifo_ack_d     = 1'b0;
        send_cfg_d     = 1'b0;
        write_regmap_d = 1'b0;
        read_regmap_d  = 1'b0;
        addr_d         = regmap_address;
        wdata_d        = regmap_write_data;
        inc_tp         = 1'b0;
        inc_bp         = 1'b0;
`ifdef COMMS_CTRL_MP_MAILBOX_EN
        pend_d    = pend;
        mb_byte_d = mb_byte;
        mb_clr    = '0;
        mb_sel    = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
        mb_base   = pend[0] ? TP_ADDR : (pend[1] ? BP_ADDR : HW_ADDR);
        mb_cnt    = pend[0] ? total_packets : (pend[1] ? bad_packets : fifo_high_water);
`endif
        // Outputs are registered, so each branch sets what the next state shows.
        case (state)
            S_READY: begin
                if (found) begin
                    rx_ack_d[grant] = 1'b1;
                    word_d  = rx_data[int'(grant)*W +: W];
                    ptr_d   = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + PW'(1);
                    state_d = S_DECODE;
                end else if (load_event) begin
                    state_d = S_LOAD_EVENT;
`ifdef COMMS_CTRL_MP_MAILBOX_EN
                end else if (|chg) begin
                    pend_d    = chg;
                    mb_byte_d = '0;
                    state_d   = S_MAILBOX;
`endif
                end
            end
            S_DECODE: begin
                if (pkt_op == 2'b00 || (pkt_op[1] && !magic_ok)) begin
                    state_d = S_BAD;
                end else if (pkt_op == 2'b10 && id_match) begin
                    write_regmap_d = 1'b1;
                    addr_d         = pkt_addr;
                    wdata_d        = pkt_data;
                    state_d        = S_CFG_WRITE;
                end else if (pkt_op == 2'b11 && id_match) begin
                    read_regmap_d = 1'b1;
                    addr_d        = pkt_addr;
                    state_d       = S_CFG_READ;
                end else if (pkt_op[1]) begin
                    output_event_d = word;
                    state_d        = S_PASS_CFG;
                end else begin
                    state_d = S_PASS;
                end
            end
            S_CFG_WRITE: state_d = is_bcast ? S_PASS : S_WAIT;
            S_CFG_READ: begin
                if (cnt == 4'(READ_LATENCY - 1)) begin
                    output_event_d          = word;
                    output_event_d[W-1]     = 1'b1;
                    output_event_d[25:18]   = regmap_read_data;
                    output_event_d[9:2]     = chip_id;
                    send_cfg_d              = 1'b1;
                    inc_tp                  = 1'b1;
                    state_d                 = is_bcast ? S_PASS : S_WAIT;
                end else begin
                    read_regmap_d = 1'b1;
                    cnt_d         = cnt + 4'd1;
                end
            end
            S_PASS: begin
                output_event_d = word;
                write_fifo_n_d = 1'b0;
                fifo_ack_d     = 1'b1;
                state_d        = S_WRITE_FIFO;
            end
            S_LOAD_EVENT: begin
                output_event_d = pre_event;
                write_fifo_n_d = 1'b0;
                fifo_ack_d     = 1'b1;
                inc_tp         = 1'b1;
                state_d        = S_WRITE_FIFO;
            end
            S_WRITE_FIFO: state_d = S_WAIT;
            S_PASS_CFG: begin
                send_cfg_d = 1'b1;
                state_d    = S_WAIT;
            end
            S_BAD: begin
                inc_bp  = 1'b1;
                state_d = S_READY;
            end
            S_WAIT: begin
                if (cnt == 4'(WAIT_CYC - 1)) state_d = S_READY;
                else cnt_d = cnt + 4'd1;
            end
`ifdef COMMS_CTRL_MP_MAILBOX_EN
            S_MAILBOX: begin
                write_regmap_d = 1'b1;
                addr_d         = mb_base + 8'(mb_byte);
                wdata_d        = mb_cnt[int'(mb_byte)*8 +: 8];
                if (mb_byte == 2'(CNT_BYTES - 1)) begin
                    mb_clr[mb_sel] = 1'b1;
                    pend_d[mb_sel] = 1'b0;
                    mb_byte_d      = '0;
                    if (pend_d == 3'b000) state_d = S_READY;
                end else begin
                    mb_byte_d = mb_byte + 2'd1;
                end
            end
`endif
            default: state_d = S_READY;
        endcase
        // Per-state cycle counter restarts on every state change.
        if (state_d != state) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_READY;
            ptr               <= '0;
            word              <= '0;
            cnt               <= '0;
            rx_ack            <= '0;
            output_event      <= '0;
            write_fifo_n      <= 1'b1;
            fifo_ack          <= 1'b0;
            send_config_data  <= 1'b0;
            write_regmap      <= 1'b0;
            read_regmap       <= 1'b0;
            regmap_address    <= '0;
            regmap_write_data <= '0;
            comms_busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the pre-edge values, independent of statement order.
            state             <= state_d;
            ptr               <= ptr_d;
            word              <= word_d;
            cnt               <= cnt_d;
            rx_ack            <= rx_ack_d;
            output_event      <= output_event_d;
            write_fifo_n      <= write_fifo_n_d;
            fifo_ack          <= fifo_ack_d;
            send_config_data  <= send_cfg_d;
            write_regmap      <= write_regmap_d;
            read_regmap       <= read_regmap_d;
            regmap_address    <= addr_d;
            regmap_write_data <= wdata_d;
            comms_busy        <= (state_d != S_READY);
        end
    end

    // Saturating counters: increment is suppressed once a counter is all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            total_packets   <= '0;
            bad_packets     <= '0;
            fifo_high_water <= '0;
        end else begin
            if (tp_set) total_packets   <= total_packets + CW'(1);
            if (bp_set) bad_packets     <= bad_packets + CW'(1);
            if (hw_set) fifo_high_water <= fc_w;
        end
    end

`ifdef COMMS_CTRL_MP_MAILBOX_EN
    // Change flags. A change to a counter while it is being mirrored is
    // remembered in redo so the flag survives the clear at its last byte.
    logic [2:0] set_vec;
    assign set_vec = {hw_set, bp_set, tp_set};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chg     <= '0;
            pend    <= '0;
            redo    <= '0;
            mb_byte <= '0;
        end else begin
            chg     <= (mb_clr & (redo | set_vec)) | (~mb_clr & (chg | set_vec));
            redo    <= ~mb_clr & (redo | ((state == S_MAILBOX) ? (pend & set_vec) : 3'b000));
            pend    <= pend_d;
            mb_byte <= mb_byte_d;
        end
    end
`endif

endmodule

// File: tb/tb_comms_ctrl_mp.sv
module tb_comms_ctrl_mp;
    localparam int          W     = 63;
    localparam int          NP    = 4;
    localparam logic [31:0] MAGIC = 32'h8950_4E47;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [NP*W-1:0]   rx_data;
    logic [NP-1:0]     rx_data_flag;
    logic [NP-1:0]     rx_ack;
    logic [W-1:0]      pre_event;
    logic              load_event;
    logic [7:0]        chip_id, regmap_read_data;
    logic [11:0]       fifo_counter;
    logic [W-1:0]      output_event;
    logic              write_fifo_n, fifo_ack, send_config_data;
    logic              write_regmap, read_regmap;
    logic [7:0]        regmap_address, regmap_write_data;
    logic [15:0]       total_packets, bad_packets, fifo_high_water;
    logic              comms_busy;

    // Second instance with 8-bit counters for saturation / truncation.
    logic [NP-1:0]     rx_data_flag2, rx_ack2;
    logic              load_event2;
    logic [W-1:0]      output_event2;
    logic              write_fifo_n2, fifo_ack2, send_config_data2;
    logic              write_regmap2, read_regmap2;
    logic [7:0]        regmap_address2, regmap_write_data2;
    logic [7:0]        total_packets2, bad_packets2, fifo_high_water2;
    logic              comms_busy2;

    comms_ctrl_mp #(.WIDTH(64), .NUM_PORTS(NP), .READ_LATENCY(5), .CNT_BYTES(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_flag(rx_data_flag),
        .rx_ack(rx_ack), .pre_event(pre_event), .load_event(load_event), .chip_id(chip_id),
        .regmap_read_data(regmap_read_data), .fifo_counter(fifo_counter),
        .output_event(output_event), .write_fifo_n(write_fifo_n), .fifo_ack(fifo_ack),
        .send_config_data(send_config_data), .write_regmap(write_regmap),
        .read_regmap(read_regmap), .regmap_address(regmap_address),
        .regmap_write_data(regmap_write_data), .total_packets(total_packets),
        .bad_packets(bad_packets), .fifo_high_water(fifo_high_water), .comms_busy(comms_busy)
    );

    comms_ctrl_mp #(.WIDTH(64), .NUM_PORTS(NP), .READ_LATENCY(5), .CNT_BYTES(1)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_flag(rx_data_flag2),
        .rx_ack(rx_ack2), .pre_event(pre_event), .load_event(load_event2), .chip_id(chip_id),
        .regmap_read_data(regmap_read_data), .fifo_counter(fifo_counter),
        .output_event(output_event2), .write_fifo_n(write_fifo_n2), .fifo_ack(fifo_ack2),
        .send_config_data(send_config_data2), .write_regmap(write_regmap2),
        .read_regmap(read_regmap2), .regmap_address(regmap_address2),
        .regmap_write_data(regmap_write_data2), .total_packets(total_packets2),
        .bad_packets(bad_packets2), .fifo_high_water(fifo_high_water2), .comms_busy(comms_busy2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] op, input logic [7:0] id,
                                        input logic [7:0] addr, input logic [7:0] data,
                                        input logic [31:0] magic, input logic [4:0] top);
        logic [W-1:0] w;
        w        = '0;
        w[1:0]   = op;
        w[9:2]   = id;
        w[17:10] = addr;
        w[25:18] = data;
        w[57:26] = magic;
        w[62:58] = top;
        return w;
    endfunction

    task automatic put_port(input int p, input logic [W-1:0] w);
        rx_data[p*W +: W] = w;
        rx_data_flag[p]   = 1'b1;
    endtask

    // Event log of one run; cycle k=1 is the cycle after the first sampling edge.
    logic [NP-1:0] ack_q[$];
    int            ackc_q[$];
    logic [W-1:0]  fifo_q[$];
    int            fifoc_q[$];
    logic [15:0]   wr_q[$];
    int            wrc_q[$];
    logic [W-1:0]  send_q[$];
    int            sendc_q[$];
    int            rd_n;

    task automatic run(input int ncyc);
        ack_q.delete(); ackc_q.delete(); fifo_q.delete(); fifoc_q.delete();
        wr_q.delete(); wrc_q.delete(); send_q.delete(); sendc_q.delete();
        rd_n = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (rx_ack != '0) begin
                ack_q.push_back(rx_ack);
                ackc_q.push_back(k);
                rx_data_flag = rx_data_flag & ~rx_ack;
            end
            if (!write_fifo_n) begin
                fifo_q.push_back(output_event);
                fifoc_q.push_back(k);
                if (output_event == pre_event) load_event = 1'b0;
            end
            if (write_regmap) begin
                wr_q.push_back({regmap_address, regmap_write_data});
                wrc_q.push_back(k);
            end
            if (send_config_data) begin
                send_q.push_back(output_event);
                sendc_q.push_back(k);
            end
            if (read_regmap) rd_n++;
        end
    endtask

    logic [W-1:0] pk0, pk2, exp_w;
    int           n_ld, n_send;

    initial begin
        reset_n = 1'b0; rx_data = '0; rx_data_flag = '0; rx_data_flag2 = '0;
        pre_event = '0; load_event = 1'b0; load_event2 = 1'b0;
        chip_id = 8'h05; regmap_read_data = 8'h00; fifo_counter = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_write_fifo_n", write_fifo_n, 1);
        check("rst_rx_ack", rx_ack, 0);
        check("rst_busy", comms_busy, 0);
        check("rst_output_event", output_event, 0);
        check("rst_total", total_packets, 0);
        reset_n = 1'b1;

        // Two data packets on ports 0 and 2: round-robin order, FIFO writes in order.
        pk0 = mk(2'b01, 8'h11, 8'h01, 8'h02, 32'h0, 5'h03);
        pk2 = mk(2'b01, 8'h22, 8'h03, 8'h04, 32'hDEAD_BEEF, 5'h1C);
        put_port(0, pk0);
        put_port(2, pk2);
        run(14);
        check("rr_ack_n", ack_q.size(), 2);
        check("rr_ack0", (ack_q.size() > 0) ? ack_q[0] : 'x, 4'b0001);
        check("rr_ack0_cyc", (ackc_q.size() > 0) ? ackc_q[0] : -1, 1);
        check("rr_ack1", (ack_q.size() > 1) ? ack_q[1] : 'x, 4'b0100);
        check("rr_ack1_cyc", (ackc_q.size() > 1) ? ackc_q[1] : -1, 6);
        check("rr_fifo_n", fifo_q.size(), 2);
        check("rr_fifo0", (fifo_q.size() > 0) ? fifo_q[0] : 'x, pk0);
        check("rr_fifo0_cyc", (fifoc_q.size() > 0) ? fifoc_q[0] : -1, 3);
        check("rr_fifo1", (fifo_q.size() > 1) ? fifo_q[1] : 'x, pk2);
        check("rr_fifo1_cyc", (fifoc_q.size() > 1) ? fifoc_q[1] : -1, 8);

        // Unicast config write.
        put_port(0, mk(2'b10, 8'h05, 8'h10, 8'hA5, MAGIC, 5'h00));
        run(10);
        check("cw_wr_n", wr_q.size(), 1);
        check("cw_wr", (wr_q.size() > 0) ? wr_q[0] : 'x, 16'h10A5);
        check("cw_wr_cyc", (wrc_q.size() > 0) ? wrc_q[0] : -1, 2);
        check("cw_fifo_n", fifo_q.size(), 0);
        check("cw_busy_end", comms_busy, 0);

        // Broadcast config read.
        regmap_read_data = 8'h3C;
        pk0   = mk(2'b11, 8'hFF, 8'h20, 8'h77, MAGIC, 5'h06);
        exp_w = pk0;
        exp_w[62]    = 1'b1;
        exp_w[25:18] = 8'h3C;
        exp_w[9:2]   = 8'h05;
        put_port(0, pk0);
        run(20);
        check("cr_read_cycles", rd_n, 5);
        check("cr_send_n", send_q.size(), 1);
        check("cr_send_word", (send_q.size() > 0) ? send_q[0] : 'x, exp_w);
        check("cr_send_cyc", (sendc_q.size() > 0) ? sendc_q[0] : -1, 7);
        check("cr_fifo_n", fifo_q.size(), 1);
        check("cr_fifo_word", (fifo_q.size() > 0) ? fifo_q[0] : 'x, pk0);
        check("cr_fifo_cyc", (fifoc_q.size() > 0) ? fifoc_q[0] : -1, 8);
        check("cr_total", total_packets, 1);
`ifdef COMMS_CTRL_MP_MAILBOX_EN
        check("cr_mb_n", wr_q.size(), 2);
        check("cr_mb0", (wr_q.size() > 0) ? wr_q[0] : 'x, 16'hF001);
        check("cr_mb1", (wr_q.size() > 1) ? wr_q[1] : 'x, 16'hF100);
`else
        check("cr_wr_n", wr_q.size(), 0);
`endif

        // Config write with bad magic.
        put_port(0, mk(2'b10, 8'h05, 8'h10, 8'hA5, 32'h0, 5'h00));
        run(10);
        check("bm_bad", bad_packets, 1);
        check("bm_fifo_n", fifo_q.size(), 0);
`ifdef COMMS_CTRL_MP_MAILBOX_EN
        check("bm_mb_n", wr_q.size(), 2);
        check("bm_mb0", (wr_q.size() > 0) ? wr_q[0] : 'x, 16'hF401);
        check("bm_mb1", (wr_q.size() > 1) ? wr_q[1] : 'x, 16'hF500);
`else
        check("bm_wr_n", wr_q.size(), 0);
`endif

        // Invalid opcode.
        put_port(0, mk(2'b00, 8'h05, 8'h10, 8'hA5, MAGIC, 5'h00));
        run(10);
        check("op0_bad", bad_packets, 2);

        // Config write addressed to another chip: passed along via send_config_data.
        pk0 = mk(2'b10, 8'h33, 8'h44, 8'h55, MAGIC, 5'h00);
        put_port(0, pk0);
        run(8);
        check("pc_send_n", send_q.size(), 1);
        check("pc_send_word", (send_q.size() > 0) ? send_q[0] : 'x, pk0);
        check("pc_send_cyc", (sendc_q.size() > 0) ? sendc_q[0] : -1, 3);
        check("pc_wr_n", wr_q.size(), 0);
        check("pc_fifo_n", fifo_q.size(), 0);

        // RX beats a simultaneous load_event, which stays pending.
        pk0 = mk(2'b01, 8'h66, 8'h01, 8'h01, 32'h0, 5'h11);
        pre_event = mk(2'b01, 8'h77, 8'h88, 8'h99, 32'h1234_5678, 5'h0A);
        put_port(1, pk0);
        load_event = 1'b1;
        run(14);
        check("pr_ack", (ack_q.size() > 0) ? ack_q[0] : 'x, 4'b0010);
        check("pr_fifo_n", fifo_q.size(), 2);
        check("pr_fifo0", (fifo_q.size() > 0) ? fifo_q[0] : 'x, pk0);
        check("pr_fifo1", (fifo_q.size() > 1) ? fifo_q[1] : 'x, pre_event);
        check("pr_fifo1_cyc", (fifoc_q.size() > 1) ? fifoc_q[1] : -1, 7);
        check("pr_total", total_packets, 2);

        // FIFO high water: zero-extended on 16 bits, truncated on 8 bits.
        fifo_counter = 12'h123;
        repeat (3) @(negedge clk);
        check("hw16_up", fifo_high_water, 16'h0123);
        check("hw8_trunc", fifo_high_water2, 8'h23);
        fifo_counter = 12'h050;
        repeat (3) @(negedge clk);
        check("hw16_hold", fifo_high_water, 16'h0123);
        check("hw8_up", fifo_high_water2, 8'h50);

        // 300 load_event passes on the 8-bit instance: total saturates at FF.
        n_ld = 0;
        load_event2 = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!write_fifo_n2) begin
                n_ld++;
                if (n_ld == 1)   check("sat_1", total_packets2, 8'h01);
                if (n_ld == 254) check("sat_254", total_packets2, 8'hFE);
                if (n_ld == 255) check("sat_255", total_packets2, 8'hFF);
                if (n_ld == 300) begin
                    load_event2 = 1'b0;
                    break;
                end
            end
        end
        load_event2 = 1'b0;
        check("sat_passes", n_ld, 300);
        check("sat_300", total_packets2, 8'hFF);

        // Reset asserted during a config read.
        put_port(0, mk(2'b11, 8'h05, 8'h21, 8'h00, MAGIC, 5'h00));
        @(negedge clk);
        check("rr_mid_ack", rx_ack, 4'b0001);
        rx_data_flag = '0;
        repeat (2) @(negedge clk);
        check("rr_mid_read", read_regmap, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_read_regmap", read_regmap, 0);
        check("mid_write_fifo_n", write_fifo_n, 1);
        check("mid_send", send_config_data, 0);
        check("mid_addr", regmap_address, 0);
        check("mid_output_event", output_event, 0);
        check("mid_total", total_packets, 0);
        check("mid_bad", bad_packets, 0);
        check("mid_hw", fifo_high_water, 0);
        check("mid_busy", comms_busy, 0);
        reset_n = 1'b1;
        n_send = 0;
        repeat (12) begin
            @(negedge clk);
            if (send_config_data || write_regmap || !write_fifo_n) n_send++;
        end
        check("mid_no_late_strobe", n_send, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
